// File: rtl/atm_light_est.sv
// Per-frame atmospheric light estimator: finds the brightest-dark pixel of each
// frame, IIR-smooths it against the previous estimate, clamps and publishes it.
module atm_light_est #(
    parameter int         SMOOTH_SHIFT = 3,
    parameter logic [7:0] A_MIN        = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       in_eof,
    output logic [7:0] A_r,
    output logic [7:0] A_g,
    output logic [7:0] A_b,
    output logic       A_valid,
    output logic [7:0] dark_max
);

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Smoothed and clamped channel; the shifted step never overshoots cand,
    // so the 10-bit result always lies between A_old and cand.
    function automatic logic [7:0] filt(input logic [7:0] cand, input logic [7:0] a_old,
                                        input logic primed_f);
        logic signed [9:0] d;
        logic signed [9:0] f;
        logic        [9:0] res;
        d   = $signed({2'b00, cand}) - $signed({2'b00, a_old});
        f   = $signed({2'b00, a_old}) + (d >>> SMOOTH_SHIFT);
        res = primed_f ? unsigned'(f) : {2'b00, cand};
        return (res < {2'b00, A_MIN}) ? A_MIN : res[7:0];
    endfunction

    // Stage 1: registered pixel with its dark value and channel sum
    logic       s1_valid, s1_sof, s1_eof;
    logic [7:0] s1_r, s1_g, s1_b, s1_dark;
    logic [9:0] s1_sum;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_dark  <= '0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sof  <= in_sof;
                s1_eof  <= in_eof;
                s1_r    <= in_r;
                s1_g    <= in_g;
                s1_b    <= in_b;
                s1_dark <= min3(in_r, in_g, in_b);
                s1_sum  <= {2'b00, in_r} + {2'b00, in_g} + {2'b00, in_b};
            end
        end
    end

    // Accumulation FSM and best-pixel tracking
    state_t     state, state_next;
    logic       accept, better, load_best, frame_end;
    logic [7:0] best_r, best_g, best_b, best_dark;
    logic [9:0] best_sum;
    logic       snap_pend;

    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        accept     = s1_valid && (s1_sof || state == ACCUM);
        better     = s1_sof || (s1_dark > best_dark) ||
                     ((s1_dark == best_dark) && (s1_sum > best_sum));
        load_best  = accept && better;
        frame_end  = accept && s1_eof;
        state_next = state;
        if (frame_end)
            state_next = IDLE;
        else if (s1_valid && s1_sof)
            state_next = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            best_r    <= '0;
            best_g    <= '0;
            best_b    <= '0;
            best_dark <= '0;
            best_sum  <= '0;
            snap_pend <= 1'b0;
        end else begin
            state     <= state_next;
            snap_pend <= frame_end;
            if (load_best) begin
                best_r    <= s1_r;
                best_g    <= s1_g;
                best_b    <= s1_b;
                best_dark <= s1_dark;
                best_sum  <= s1_sum;
            end
        end
    end

    // Snapshot reads best before a restarting frame overwrites it on this edge
    logic       cand_valid;
    logic [7:0] cand_r, cand_g, cand_b, cand_dark;
    logic       primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_valid <= 1'b0;
            cand_r     <= '0;
            cand_g     <= '0;
            cand_b     <= '0;
            cand_dark  <= '0;
        end else begin
            cand_valid <= snap_pend;
            if (snap_pend) begin
                cand_r    <= best_r;
                cand_g    <= best_g;
                cand_b    <= best_b;
                cand_dark <= best_dark;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A_r      <= 8'hFF;
            A_g      <= 8'hFF;
            A_b      <= 8'hFF;
            A_valid  <= 1'b0;
            dark_max <= '0;
            primed   <= 1'b0;
        end else begin
            A_valid <= cand_valid;
            if (cand_valid) begin
                A_r      <= filt(cand_r, A_r, primed);
                A_g      <= filt(cand_g, A_g, primed);
                A_b      <= filt(cand_b, A_b, primed);
                dark_max <= cand_dark;
                primed   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_atm_light_est.sv
// Self-checking bench for atm_light_est: directed scenarios plus random frames
// compared against a frame-level behavioural model.
module tb_atm_light_est;

    localparam int SHIFT = 3;
    localparam int AMIN  = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_r, in_g, in_b;
    logic       in_valid, in_sof, in_eof;
    logic [7:0] A_r, A_g, A_b;
    logic       A_valid;
    logic [7:0] dark_max;

    atm_light_est #(.SMOOTH_SHIFT(SHIFT), .A_MIN(8'(AMIN))) dut (
        .clk(clk), .rst(rst),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .A_r(A_r), .A_g(A_g), .A_b(A_b), .A_valid(A_valid), .dark_max(dark_max)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    always @(negedge clk) if (A_valid === 1'b1) pulse_cnt++;

    typedef struct {int r; int g; int b;} pix_t;
    pix_t frame_q[$];

    int m_a[3];
    bit m_primed;
    int exp_a[3];
    int exp_dark;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
    endtask

    task automatic model_reset();
        m_primed = 1'b0;
        for (int c = 0; c < 3; c++) m_a[c] = 255;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_pix(input int r, input int g, input int b, input bit sof, input bit eof);
        in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
        in_sof = sof; in_eof = eof; in_valid = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_pix(frame_q[i].r, frame_q[i].g, frame_q[i].b, i == 0, i == frame_q.size() - 1);
            if (max_gap > 0 && i != frame_q.size() - 1)
                repeat ($urandom_range(0, max_gap)) step();
        end
    endtask

    function automatic int floor_div(input int d);
        int p;
        p = 1 << SHIFT;
        if (d >= 0) return d / p;
        return -((-d + p - 1) / p);
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Winner of frame_q, then smoothing and clamp against the model's A
    task automatic model_frame();
        int bd, bs, bi, d, s, f;
        int cand[3];
        bd = -1; bs = -1; bi = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            d = min3(frame_q[i].r, frame_q[i].g, frame_q[i].b);
            s = frame_q[i].r + frame_q[i].g + frame_q[i].b;
            if (d > bd || (d == bd && s > bs)) begin
                bd = d; bs = s; bi = i;
            end
        end
        cand[0] = frame_q[bi].r; cand[1] = frame_q[bi].g; cand[2] = frame_q[bi].b;
        for (int c = 0; c < 3; c++) begin
            f = m_primed ? m_a[c] + floor_div(cand[c] - m_a[c]) : cand[c];
            if (f < AMIN) f = AMIN;
            m_a[c] = f;
            exp_a[c] = f;
        end
        exp_dark = bd;
        m_primed = 1'b1;
    endtask

    task automatic compare_a(input string name);
        checks++;
        if (A_r !== 8'(exp_a[0]) || A_g !== 8'(exp_a[1]) || A_b !== 8'(exp_a[2]) ||
            dark_max !== 8'(exp_dark)) begin
            errors++;
            $display("FAIL %s: got A=(%0d,%0d,%0d) dark=%0d, expected A=(%0d,%0d,%0d) dark=%0d",
                     name, A_r, A_g, A_b, dark_max, exp_a[0], exp_a[1], exp_a[2], exp_dark);
        end
    endtask

    // Wait (bounded) for the next publish, compare it, and confirm the pulse ends
    task automatic check_pub(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (A_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no A_valid, expected a pulse", name);
        end else begin
            compare_a(name);
            step();
            checks++;
            if (A_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_pulse_width: got A_valid=%b, expected 0", name, A_valid);
            end
        end
    endtask

    task automatic check_quiet(input string name, input int p0);
        checks++;
        if (pulse_cnt != p0 || A_r !== 8'hFF || A_g !== 8'hFF || A_b !== 8'hFF || dark_max !== 8'h00) begin
            errors++;
            $display("FAIL %s: got pulses=%0d A=(%0d,%0d,%0d) dark=%0d, expected 0 pulses A=255 dark=0",
                     name, pulse_cnt - p0, A_r, A_g, A_b, dark_max);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (A_r !== 8'hFF || A_g !== 8'hFF || A_b !== 8'hFF || A_valid !== 1'b0 || dark_max !== 8'h00) begin
            errors++;
            $display("FAIL reset: got A=(%0d,%0d,%0d) valid=%b dark=%0d, expected (255,255,255) 0 0",
                     A_r, A_g, A_b, A_valid, dark_max);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        frame_q = '{'{10, 20, 30}, '{200, 180, 190}, '{50, 50, 50}, '{180, 200, 190}};
        send_frame(0);
        model_frame();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (A_valid !== (i == 3)) begin
                errors++;
                $display("FAIL latency_edge_%0d: got A_valid=%b, expected %b", i, A_valid, i == 3);
            end
        end
        compare_a("single_frame");
        step();
        checks++;
        if (A_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got A_valid=%b, expected 0", A_valid);
        end
        compare_a("single_frame_hold");
    endtask

    task automatic test_tie();
        do_reset();
        frame_q = '{'{100, 120, 110}, '{110, 100, 130}};
        send_frame(0);
        model_frame();
        check_pub("tie_order_a");
        frame_q = '{'{110, 100, 130}, '{100, 120, 110}};
        send_frame(1);
        model_frame();
        check_pub("tie_order_b");
    endtask

    task automatic test_smoothing();
        do_reset();
        frame_q = '{'{90, 100, 80}, '{200, 200, 200}, '{210, 150, 255}};
        send_frame(0); model_frame(); check_pub("smooth_1");
        frame_q = '{'{120, 120, 120}, '{60, 255, 255}};
        send_frame(0); model_frame(); check_pub("smooth_2");
        frame_q = '{'{100, 100, 100}, '{250, 250, 250}};
        send_frame(0); model_frame(); check_pub("smooth_3");
    endtask

    task automatic test_clamp();
        do_reset();
        frame_q = '{'{20, 30, 40}, '{20, 30, 40}, '{20, 30, 40}};
        send_frame(0);
        model_frame();
        check_pub("clamp");
    endtask

    task automatic test_abort();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        send_pix(255, 255, 255, 1'b1, 1'b0);
        send_pix(10, 20, 30, 1'b0, 1'b0);
        send_pix(30, 40, 50, 1'b0, 1'b0);
        frame_q = '{'{90, 90, 90}, '{40, 50, 60}};
        send_frame(0);
        model_frame();
        check_pub("abort");
        repeat (6) step();
        checks++;
        if (pulse_cnt - p0 != 1) begin
            errors++;
            $display("FAIL abort_pulses: got %0d pulses, expected 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        int e1[3];
        int d1;
        do_reset();
        frame_q = '{'{150, 160, 170}};
        send_frame(0);
        model_frame();
        e1 = exp_a; d1 = exp_dark;
        frame_q = '{'{100, 100, 100}};
        send_frame(0);
        model_frame();
        step();
        checks++;
        if (A_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: got A_valid=%b, expected 0", A_valid);
        end
        step();
        checks++;
        if (A_valid !== 1'b1 || A_r !== 8'(e1[0]) || A_g !== 8'(e1[1]) || A_b !== 8'(e1[2]) ||
            dark_max !== 8'(d1)) begin
            errors++;
            $display("FAIL b2b_first: got valid=%b A=(%0d,%0d,%0d) dark=%0d, expected 1 (%0d,%0d,%0d) %0d",
                     A_valid, A_r, A_g, A_b, dark_max, e1[0], e1[1], e1[2], d1);
        end
        step();
        checks++;
        if (A_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_valid: got A_valid=%b, expected 1", A_valid);
        end
        compare_a("b2b_second");
        step();
        checks++;
        if (A_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got A_valid=%b, expected 0", A_valid);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        send_pix(200, 210, 220, 1'b1, 1'b0);
        send_pix(180, 190, 200, 1'b0, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        model_reset();
        send_pix(240, 240, 240, 1'b0, 1'b1);
        repeat (8) step();
        check_quiet("reset_mid_frame", p0);

        p0 = pulse_cnt;
        send_pix(120, 130, 140, 1'b1, 1'b1);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        model_reset();
        repeat (8) step();
        check_quiet("reset_mid_publish", p0);

        frame_q = '{'{30, 200, 100}};
        send_frame(0);
        model_frame();
        check_pub("after_reset_unprimed");
    endtask

    task automatic test_random();
        int n, lo, hi;
        pix_t p;
        do_reset();
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 3) == 0)
                send_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                         1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 0) begin lo = 0; hi = 3; end
            else begin lo = 0; hi = 255; end
            frame_q.delete();
            for (int i = 0; i < n; i++) begin
                if (hi == 3) begin
                    p.r = $urandom_range(lo, hi) * 80;
                    p.g = $urandom_range(lo, hi) * 80;
                    p.b = $urandom_range(lo, hi) * 80;
                end else begin
                    p.r = $urandom_range(lo, hi);
                    p.g = $urandom_range(lo, hi);
                    p.b = $urandom_range(lo, hi);
                end
                frame_q.push_back(p);
            end
            send_frame(2);
            model_frame();
            check_pub($sformatf("random_%0d", f));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_frame();
        test_tie();
        test_smoothing();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
